// File: rtl/charlie7x5_if.sv
// Wishbone classic bus bundle between the system bus and the charlieplex LED driver.
// Signal names keep the slave-side _i/_o suffixes used throughout the top level.
interface charlie7x5_if;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic [2:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;

  modport master (
    output wb_cyc_i,
    output wb_stb_i,
    output wb_we_i,
    output wb_adr_i,
    output wb_dat_i,
    input  wb_dat_o,
    input  wb_ack_o
  );

  modport slave (
    input  wb_cyc_i,
    input  wb_stb_i,
    input  wb_we_i,
    input  wb_adr_i,
    input  wb_dat_i,
    output wb_dat_o,
    output wb_ack_o
  );
endinterface

// File: rtl/charlie7x5.sv
// Wishbone-slave driver for a 5x7 charlieplexed LED matrix on seven tri-state pins:
// double-buffered framebuffer, one anode per phase, dead time at the start of each phase.
module charlie7x5 #(
  parameter int TICKS_PER_PHASE = 48000,
  parameter int DEAD_TICKS      = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  charlie7x5_if.slave wb,
  output logic [6:0]  charlie7x5_oe,
  output logic [6:0]  charlie7x5_o
);

  localparam int               CNT_W       = $clog2(TICKS_PER_PHASE);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICKS_PER_PHASE - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD    = CNT_W'(DEAD_TICKS);
  localparam logic [2:0]       ANODE_FIRST = 3'd0;
  localparam logic [2:0]       ANODE_LAST  = 3'd6;
  localparam logic [2:0]       ADR_CTRL    = 3'd5;

  logic             bus_req;
  logic             ack_q;
  logic [7:0]       dat_q;
  logic             req_we;
  logic [2:0]       req_adr;
  logic [7:0]       req_dat;
  logic [7:0]       rd_mux;
  logic             wr_stb;
  logic             ctrl_wr;
  logic             commit_set;
  logic             unused_bits;

  logic [6:0]       back_col  [5];
  logic [6:0]       front_col [5];
  logic [34:0]      front_flat;
  logic [63:0]      front_pad;
  logic             enable;
  logic             enable_d;
  logic             enable_nxt;
  logic             pending;
  logic             frame_end;
  logic             swap;

  logic [2:0]       a;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       anode_bit;
  logic [6:0]       pat_oe;
  logic [6:0]       pat_o;
  logic [5:0]       k_idx;
  logic [2:0]       cath;

  assign bus_req     = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign unused_bits = req_dat[7];

  always_comb begin
    rd_mux = 8'h00;
    for (int x = 0; x < 5; x++) begin
      if (wb.wb_adr_i == 3'(x)) rd_mux = {1'b0, back_col[x]};
    end
    if (wb.wb_adr_i == ADR_CTRL) rd_mux = {6'b0, pending, enable};
  end

  // The request is latched so the write can land at the end of the ack cycle
  // regardless of what the master does with the bus after seeing ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      dat_q   <= 8'h00;
      req_we  <= 1'b0;
      req_adr <= 3'd0;
      req_dat <= 8'h00;
    end else begin
      ack_q <= bus_req;
      dat_q <= bus_req ? rd_mux : 8'h00;
      if (bus_req) begin
        req_we  <= wb.wb_we_i;
        req_adr <= wb.wb_adr_i;
        req_dat <= wb.wb_dat_i;
      end
    end
  end

  assign wr_stb     = ack_q & req_we;
  assign ctrl_wr    = wr_stb & (req_adr == ADR_CTRL);
  assign commit_set = ctrl_wr & req_dat[1];
  assign enable_nxt = ctrl_wr ? req_dat[0] : enable;
  assign frame_end  = enable & (a == ANODE_LAST) & (cnt == CNT_LAST);

  // The cycle ENABLE rises the scanner is still parked at frame start, so a
  // commit written together with ENABLE swaps immediately instead of a frame late.
  assign swap = pending & (frame_end | ~enable | ~enable_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      enable_d <= 1'b0;
      pending  <= 1'b0;
      for (int x = 0; x < 5; x++) begin
        back_col[x]  <= 7'h00;
        front_col[x] <= 7'h00;
      end
    end else begin
      enable   <= enable_nxt;
      enable_d <= enable;
      if (commit_set)  pending <= 1'b1;
      else if (swap)   pending <= 1'b0;
      for (int x = 0; x < 5; x++) begin
        if (swap) front_col[x] <= back_col[x];
        if (wr_stb && req_adr == 3'(x)) back_col[x] <= req_dat[6:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= ANODE_FIRST;
      cnt <= '0;
    end else if (!enable || !enable_nxt) begin
      a   <= ANODE_FIRST;
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      a   <= (a == ANODE_LAST) ? ANODE_FIRST : a + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pixel k = 7x + y, which is exactly the bit order of the concatenated columns;
  // anode a owns k = 6a .. 6a+5 and the padding keeps k = 35..41 dark.
  assign front_flat = {front_col[4], front_col[3], front_col[2], front_col[1], front_col[0]};
  assign front_pad  = {29'b0, front_flat};
  assign anode_bit  = 7'b1 << a;

  always_comb begin
    pat_oe = 7'b0;
    pat_o  = 7'b0;
    k_idx  = 6'd0;
    cath   = 3'd0;
    if (cnt >= CNT_DEAD) begin
      pat_oe = anode_bit;
      pat_o  = anode_bit;
      for (int j = 0; j < 6; j++) begin
        k_idx = 6'(a) * 6'd6 + 6'(j);
        cath  = (3'(j) < a) ? 3'(j) : 3'(j + 1);
        if (front_pad[k_idx]) pat_oe = pat_oe | (7'b1 << cath);
      end
    end
  end

  // Gating with enable_nxt blanks the pins on the cycle right after a disabling ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      charlie7x5_oe <= 7'b0;
      charlie7x5_o  <= 7'b0;
    end else if (enable && enable_nxt) begin
      charlie7x5_oe <= pat_oe;
      charlie7x5_o  <= pat_o;
    end else begin
      charlie7x5_oe <= 7'b0;
      charlie7x5_o  <= 7'b0;
    end
  end

endmodule

// File: tb/tb_charlie7x5.sv
// Directed bench for charlie7x5: bus transfers, commit timing, scan patterns and async reset.
// A cycle-indexed reference of the scan runs alongside the directed literal checks.
module tb_charlie7x5;

  localparam int TPP   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 7 * TPP;
  localparam int NEVER = 1000000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] oe;
  logic [6:0] o;

  always #5 clk = ~clk;

  charlie7x5_if wb();

  charlie7x5 #(.TICKS_PER_PHASE(TPP), .DEAD_TICKS(DEAD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb),
    .charlie7x5_oe (oe),
    .charlie7x5_o  (o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc_n    = 0;
  int          scan_start = NEVER;
  int          stop_m   = NEVER;
  int          swap_s   = NEVER;
  logic [34:0] front_old = '0;
  logic [34:0] front_new = '0;
  bit          mon_on   = 1'b0;
  logic [13:0] exp_v;
  logic        ack_prev = 1'b0;
  int          ack_consec = 0;
  logic        ack_seen = 1'b0;
  logic [7:0]  rd;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Expected {oe, o} seen after the edge that brought the cycle counter to m.
  function automatic logic [13:0] model_out(input int m);
    int s, an, cn, k, j, c;
    logic [34:0] f;
    logic [6:0]  e_oe, e_o;
    e_oe = '0;
    e_o  = '0;
    s = m - scan_start;
    if (m >= stop_m || s < 0) return 14'b0;
    an = (s / TPP) % 7;
    cn = s % TPP;
    f  = (s >= swap_s) ? front_new : front_old;
    if (cn >= DEAD) begin
      e_oe[an] = 1'b1;
      e_o[an]  = 1'b1;
      for (int x = 0; x < 5; x++) begin
        for (int y = 0; y < 7; y++) begin
          k = 7 * x + y;
          if (f[k] && (k / 6) == an) begin
            j = k % 6;
            c = (j < an) ? j : j + 1;
            e_oe[c] = 1'b1;
          end
        end
      end
    end
    return {e_oe, e_o};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      exp_v = model_out(cyc_n);
      checkOutput("scan_oe", 32'(oe), 32'(exp_v[13:7]));
      checkOutput("scan_o", 32'(o), 32'(exp_v[6:0]));
    end
  end

  always @(negedge clk) begin
    if (wb.wb_ack_o === 1'b1 && ack_prev === 1'b1) ack_consec <= ack_consec + 1;
    if (wb.wb_ack_o === 1'b1) ack_seen <= 1'b1;
    ack_prev <= wb.wb_ack_o;
  end

  task automatic applyStimulus(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                               output logic [7:0] rdata);
    int n;
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_dat_i = dat;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (wb.wb_ack_o !== 1'b1 && n < 8);
    checkOutput("ack_latency", 32'(n), 32'd1);
    rdata = wb.wb_dat_o;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] adr, input logic [7:0] dat);
    logic [7:0] d;
    applyStimulus(1'b1, adr, dat, d);
  endtask

  task automatic wb_read_check(input logic [2:0] adr, input logic [7:0] expv, input string tag);
    logic [7:0] d;
    applyStimulus(1'b0, adr, 8'h00, d);
    checkOutput(tag, 32'(d), 32'(expv));
  endtask

  task automatic wait_until(input int target);
    while (cyc_n < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_pins(input string tag, input logic [6:0] e_oe, input logic [6:0] e_o);
    checkOutput({tag, "_oe"}, 32'(oe), 32'(e_oe));
    checkOutput({tag, "_o"}, 32'(o), 32'(e_o));
  endtask

  // Swap lands on the first a:6->0 edge strictly after the edge applying the commit.
  task automatic schedule_swap(input logic [34:0] nf);
    int w;
    w = cyc_n - scan_start + 1;
    front_old = front_new;
    swap_s    = FRAME * ((w + 1) / FRAME + 1);
    front_new = nf;
  endtask

  initial begin
    int t;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 3'd0;
    wb.wb_dat_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_pins("in_reset", 7'b0, 7'b0);
    rst_n = 1'b1;
    ack_seen = 1'b0;
    checkOutput("reset_ack", 32'(wb.wb_ack_o), 32'd0);

    repeat (100) @(posedge clk);
    #1;
    check_pins("idle", 7'b0, 7'b0);
    checkOutput("idle_no_ack", 32'(ack_seen), 32'd0);
    for (int r = 0; r < 8; r++) wb_read_check(3'(r), 8'h00, "reset_reg");

    $display("[TB] COL0=0x01 with enable+commit");
    wb_write(3'd0, 8'h01);
    wb_write(3'd5, 8'h03);
    scan_start = cyc_n + 2;
    front_old  = 35'h1;
    front_new  = 35'h1;
    mon_on     = 1'b1;
    wait_until(scan_start + 1);
    check_pins("ph0_dead", 7'b0000000, 7'b0000000);
    wait_until(scan_start + 2);
    check_pins("ph0_first", 7'b0000011, 7'b0000001);
    wait_until(scan_start + 3 * TPP + 5);
    check_pins("ph3", 7'b0001000, 7'b0001000);
    wait_until(scan_start + 6 * TPP + 7);
    check_pins("ph6", 7'b1000000, 7'b1000000);
    wb_read_check(3'd5, 8'h01, "ctrl_after_commit");
    wb_read_check(3'd0, 8'h01, "col0_readback");

    $display("[TB] COL4=0x40 commit while scanning");
    wait_until(scan_start + FRAME + 10);
    wb_write(3'd4, 8'h40);
    wb_write(3'd5, 8'h03);
    schedule_swap(front_new | (35'h40 << 28));
    wb_read_check(3'd4, 8'h40, "col4_readback");
    wait_until(scan_start + swap_s + 5 * TPP + 3);
    check_pins("ph5_col4", 7'b0110000, 7'b0100000);

    $display("[TB] mid-frame COL0=0x7F commit");
    wait_until(scan_start + swap_s + FRAME + 12);
    wb_write(3'd0, 8'h7F);
    wb_write(3'd5, 8'h03);
    schedule_swap({front_new[34:7], 7'h7F});
    wb_read_check(3'd5, 8'h03, "ctrl_pending");
    wait_until(scan_start + swap_s - TPP + 2);
    check_pins("pre_swap_ph6", 7'b1000000, 7'b1000000);
    wait_until(scan_start + swap_s - FRAME + 3);
    t = cyc_n;
    wait_until(scan_start + swap_s + 3);
    check_pins("post_swap_ph0", 7'b1111111, 7'b0000001);
    wait_until(scan_start + swap_s + TPP + 3);
    check_pins("post_swap_ph1", 7'b0000011, 7'b0000010);
    wb_read_check(3'd5, 8'h01, "ctrl_after_swap");

    $display("[TB] disable mid-phase, then re-enable");
    t = cyc_n - scan_start;
    wait_until(scan_start + (t / FRAME + 1) * FRAME + 2 * TPP + 3);
    wb_write(3'd5, 8'h00);
    stop_m = cyc_n + 1;
    wait_until(cyc_n + 1);
    check_pins("disable", 7'b0, 7'b0);
    wait_until(cyc_n + 5);
    wb_write(3'd5, 8'h01);
    front_old  = front_new;
    swap_s     = NEVER;
    scan_start = cyc_n + 2;
    stop_m     = NEVER;
    wait_until(scan_start);
    check_pins("restart_dead0", 7'b0, 7'b0);
    wait_until(scan_start + 1);
    check_pins("restart_dead1", 7'b0, 7'b0);
    wait_until(scan_start + 2);
    check_pins("restart_ph0", 7'b1111111, 7'b0000001);

    $display("[TB] back-to-back strobes and unmapped addresses");
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 3'd6;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("b2b_ack", 32'(wb.wb_ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("b2b_dat", 32'(wb.wb_dat_o), 32'd0);
    end
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb_write(3'd7, 8'hFF);
    wb_write(3'd6, 8'hFF);
    wb_read_check(3'd7, 8'h00, "adr7_read");
    wb_read_check(3'd6, 8'h00, "adr6_read");
    wb_read_check(3'd5, 8'h01, "ctrl_untouched");
    wb_read_check(3'd0, 8'h7F, "col0_untouched");

    $display("[TB] async reset during scan");
    t = cyc_n - scan_start;
    wait_until(scan_start + (t / FRAME + 1) * FRAME + 4);
    check_pins("pre_reset", 7'b1111111, 7'b0000001);
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_pins("async_reset", 7'b0, 7'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb_read_check(3'd0, 8'h00, "post_reset_col0");
    wb_read_check(3'd5, 8'h00, "post_reset_ctrl");
    repeat (4) @(posedge clk);
    #1;
    check_pins("post_reset_idle", 7'b0, 7'b0);
    checkOutput("ack_consecutive", 32'(ack_consec), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/charlie7x5.md
# charlie7x5

Wishbone-slave driver for the 5×7 charlieplexed LED matrix on seven tri-state pins. It holds a double-buffered 35-pixel framebuffer and scans it one anode pin at a time, with dead time between phases. It produces the per-pin output-enable/output pairs that feed the board's SB_IO cells directly, and it lives inside `top`.

## Interface
- `TICKS_PER_PHASE`, 48000: clock cycles per anode phase (1 ms at 48 MHz). Must be ≥ 2.
- `DEAD_TICKS`, 480: blanking cycles at the start of each phase. Must satisfy 1 ≤ DEAD_TICKS < TICKS_PER_PHASE.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `wb_cyc_i`, in, 1: Wishbone cycle.
- `wb_stb_i`, in, 1: Wishbone strobe.
- `wb_we_i`, in, 1: write enable.
- `wb_adr_i`, in, 3: register address.
- `wb_dat_i`, in, 8: write data.
- `wb_dat_o`, out, 8: read data.
- `wb_ack_o`, out, 1: transfer acknowledge.
- `charlie7x5_oe`, out, 7: per-pin output enable. 1 = driven, 0 = hi-Z.
- `charlie7x5_o`, out, 7: per-pin output level, meaningful only where oe = 1.

## Operation
Registers:
- 0–4, COLx: bits [6:0] hold back-buffer column x, where bit y is pixel (x, y). Read/write; bit 7 reads 0.
- 5, CTRL:
  - bit0 ENABLE, read/write.
  - bit1 COMMIT: writing 1 sets `pending`. Reads return `pending`.
  - Writing 0 to bit1 has no effect.
- 6–7: read 0; writes ignored; still acknowledged.

Wishbone handshake (classic, single-cycle):
- When `wb_cyc_i & wb_stb_i & !wb_ack_o`, `wb_ack_o` = 1 on the next cycle, for exactly one cycle.
- `wb_dat_o` is valid in the ack cycle and 0 otherwise.
- The write takes effect in the ack cycle.

Pixel mapping:
- k = 7x + y. Anode a = k / 6, j = k % 6.
- Cathode c = j if j < a, else j + 1.
- k = 35..41 do not exist and are never lit.

Scanner:
- State: anode `a` (0..6) and phase counter `cnt` (0..TICKS_PER_PHASE−1). Both reset to 0.
- ENABLE = 0: `a` and `cnt` held at 0; outputs all 0.
- ENABLE = 1: `cnt` increments each cycle. At TICKS_PER_PHASE−1, `cnt` goes to 0 and `a` advances, with 6 wrapping to 0.
- Frame boundary is the transition a: 6→0. If `pending`, the front buffer loads the back buffer and `pending` clears in the same cycle.
- While ENABLE = 0, a pending commit is applied on the next cycle.
- Drive pattern for phase `a`:
  - During `cnt` < DEAD_TICKS: oe = 0, o = 0.
  - Otherwise: oe[a] = 1 and o[a] = 1. For each lit front pixel with anode a, oe[c] = 1 and o[c] = 0. All other bits are 0.
- The anode is driven during the active window even when no cathode is lit.
- A COMMIT written in the same cycle as the frame boundary applies at the next frame boundary.
- Simultaneous COLx write and swap: the swap copies the pre-write back buffer.

## Timing
- Reset values: all outputs 0; both buffers 0; ENABLE 0; pending 0; `a` 0; `cnt` 0.
- Reset assertion mid-scan forces outputs to 0 immediately (asynchronously).
- Outputs are registered and lag (`a`, `cnt`) by one cycle.
- The first active phase after the ENABLE write begins with `cnt` = 0 on the cycle following the ack. The first pattern appears one cycle later.
- Frame period is 7 × TICKS_PER_PHASE cycles. Each phase has DEAD_TICKS blank cycles followed by TICKS_PER_PHASE − DEAD_TICKS driven cycles.
- Read latency is 1 cycle. No wait states.
- ENABLE cleared mid-phase: outputs are 0 one cycle after the ack, and the next enable restarts at a = 0.

## Test plan
Use TICKS_PER_PHASE = 8 and DEAD_TICKS = 2 unless stated otherwise.
- Reset, then idle 100 cycles → oe = 0, o = 0, ack never asserted, all register reads return 0x00.
- Write COL0 = 0x01, then CTRL = 0x03 → phase 0 shows 2 cycles of 0, then 6 cycles of oe = 7'b0000011, o = 7'b0000001. Phases 1–5 show oe = o = (1 << a). Phase 6 shows oe = o = 7'b1000000. Read CTRL → 0x01.
- Write COL4 = 0x40 with commit → phase 5 shows oe = 7'b0110000, o = 7'b0100000.
- Mid-frame write COL0 = 0x7F with commit → display is unchanged until the a: 6→0 boundary. CTRL reads 0x03 until then and 0x01 after.
- Write ENABLE = 0 mid-phase → outputs are 0 one cycle after the ack. Re-enable → phase 0 restarts after exactly 2 blank cycles.
- Back-to-back strobes, and reads of addresses 6–7 → ack pulses are one cycle each and never consecutive; reads return 0x00; `rst_n` low during scan → outputs 0 the same cycle.
